// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus stage.
// Opcode encodings and the default write-back mask.
package cdb_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd5;

  localparam logic [15:0] WB_MASK_DEFAULT =
    (16'd1 << OP_ADD) | (16'd1 << OP_SUB) |
    (16'd1 << OP_MUL) | (16'd1 << OP_DIV);

  function automatic logic wbEnable(
    input logic [15:0] mask,
    input logic [3:0]  op,
    input logic        destNonZero
  );
    return mask[op] & destNonZero;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr, wrapping at N-1.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // first requester at or above ptr wins
  always_comb begin
    int   j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Common-data-bus stage: per-channel holding buffers,
// round-robin broadcast and register-bank write port.
module cdb_broadcast_arbiter
  import cdb_pkg::*;
#(
  parameter int          NUM_SRC = 4,
  parameter int          DATA_W  = 16,
  parameter int          TAG_W   = 3,
  parameter int          REG_AW  = 3,
  parameter logic [15:0] WB_MASK = WB_MASK_DEFAULT,
  localparam int         SW      = $clog2(NUM_SRC)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*REG_AW-1:0]   src_dest,
  input  logic [NUM_SRC*4-1:0]        src_op,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [SW-1:0]               cdb_src,
  output logic                        rf_we,
  output logic [REG_AW-1:0]           rf_addr,
  output logic [DATA_W-1:0]           rf_data,
  output logic [15:0]                 bcast_count
);

  logic [NUM_SRC-1:0] holdValid;
  logic [TAG_W-1:0]   holdTag  [NUM_SRC];
  logic [REG_AW-1:0]  holdDest [NUM_SRC];
  logic [3:0]         holdOp   [NUM_SRC];
  logic [DATA_W-1:0]  holdData [NUM_SRC];

  logic [SW-1:0]      rrPtr;
  logic [NUM_SRC-1:0] gnt;
  logic [SW-1:0]      gntIdx;
  logic               anyHeld;

  logic               cdbValid;
  logic [TAG_W-1:0]   cdbTag;
  logic [DATA_W-1:0]  cdbData;
  logic [SW-1:0]      cdbSrc;
  logic               rfWe;
  logic [REG_AW-1:0]  rfAddr;
  logic [DATA_W-1:0]  rfData;
  logic [15:0]        bcastCount;

  assign anyHeld = |holdValid;

  rr_arbiter #(.N(NUM_SRC)) uArb (
    .req     (holdValid),
    .ptr     (rrPtr),
    .gnt     (gnt),
    .gnt_idx (gntIdx)
  );

  // buffers, broadcast registers, pointer and counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      holdValid  <= '0;
      rrPtr      <= '0;
      cdbValid   <= 1'b0;
      cdbTag     <= '0;
      cdbData    <= '0;
      cdbSrc     <= '0;
      rfWe       <= 1'b0;
      rfAddr     <= '0;
      rfData     <= '0;
      bcastCount <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        holdTag[i]  <= '0;
        holdDest[i] <= '0;
        holdOp[i]   <= '0;
        holdData[i] <= '0;
      end
    end else if (flush) begin
      holdValid <= '0;
      cdbValid  <= 1'b0;
      rfWe      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (gnt[i]) begin
          holdValid[i] <= 1'b0;
        end else if (src_valid[i] && !holdValid[i]) begin
          holdValid[i] <= 1'b1;
          holdTag[i]   <= src_tag[i*TAG_W +: TAG_W];
          holdDest[i]  <= src_dest[i*REG_AW +: REG_AW];
          holdOp[i]    <= src_op[i*4 +: 4];
          holdData[i]  <= src_data[i*DATA_W +: DATA_W];
        end
      end
      cdbValid <= anyHeld;
      rfWe     <= 1'b0;
      if (anyHeld) begin
        cdbTag     <= holdTag[gntIdx];
        cdbData    <= holdData[gntIdx];
        cdbSrc     <= gntIdx;
        rfAddr     <= holdDest[gntIdx];
        rfData     <= holdData[gntIdx];
        rfWe       <= wbEnable(WB_MASK, holdOp[gntIdx],
                               |holdDest[gntIdx]);
        bcastCount <= bcastCount + 16'd1;
        rrPtr      <= (gntIdx == SW'(NUM_SRC - 1))
                      ? '0 : gntIdx + 1'b1;
      end
    end
  end

  assign src_ready   = ~holdValid;
  assign cdb_valid   = cdbValid;
  assign cdb_tag     = cdbTag;
  assign cdb_data    = cdbData;
  assign cdb_src     = cdbSrc;
  assign rf_we       = rfWe;
  assign rf_addr     = rfAddr;
  assign rf_data     = rfData;
  assign bcast_count = bcastCount;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter.
// Four channels, default widths and write-back mask.
module tb_cdb_broadcast_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  srcValid = '0;
  logic [3:0]  srcReady;
  logic [11:0] srcTag = '0;
  logic [11:0] srcDest = '0;
  logic [15:0] srcOp = '0;
  logic [63:0] srcData = '0;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [15:0] cdbData;
  logic [1:0]  cdbSrc;
  logic        rfWe;
  logic [2:0]  rfAddr;
  logic [15:0] rfData;
  logic [15:0] bcastCount;

  int nChecks = 0;
  int nBad = 0;
  int expCount = 0;
  int grants [4];

  always #5 clock = ~clock;

  cdb_broadcast_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .src_valid   (srcValid),
    .src_ready   (srcReady),
    .src_tag     (srcTag),
    .src_dest    (srcDest),
    .src_op      (srcOp),
    .src_data    (srcData),
    .cdb_valid   (cdbValid),
    .cdb_tag     (cdbTag),
    .cdb_data    (cdbData),
    .cdb_src     (cdbSrc),
    .rf_we       (rfWe),
    .rf_addr     (rfAddr),
    .rf_data     (rfData),
    .bcast_count (bcastCount)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input int ch, input logic [2:0] tag,
                       input logic [2:0] dest, input logic [3:0] op,
                       input logic [15:0] data);
    srcValid[ch]        = 1'b1;
    srcTag[ch*3 +: 3]   = tag;
    srcDest[ch*3 +: 3]  = dest;
    srcOp[ch*4 +: 4]    = op;
    srcData[ch*16 +: 16] = data;
  endtask

  initial begin
    // reset values
    tick();
    tick();
    chk("rst_ready", 32'(srcReady), 32'hF);
    chk("rst_cdbv", 32'(cdbValid), 0);
    chk("rst_rfwe", 32'(rfWe), 0);
    chk("rst_cnt", 32'(bcastCount), 0);
    reset_n = 1'b1;
    tick();

    // single result on channel 1
    offer(1, 3'd3, 3'd5, 4'd0, 16'h00AA);
    tick();
    srcValid = '0;
    chk("one_ready", 32'(srcReady), 32'hD);
    chk("one_early", 32'(cdbValid), 0);
    tick();
    expCount++;
    chk("one_cdbv", 32'(cdbValid), 1);
    chk("one_tag", 32'(cdbTag), 3);
    chk("one_src", 32'(cdbSrc), 1);
    chk("one_data", 32'(cdbData), 32'h00AA);
    chk("one_rfwe", 32'(rfWe), 1);
    chk("one_addr", 32'(rfAddr), 5);
    chk("one_rfd", 32'(rfData), 32'h00AA);
    chk("one_cnt", 32'(bcastCount), 32'(expCount));
    tick();
    chk("one_pulse", 32'(cdbValid), 0);

    // reset mid-transfer drops pending channel 2
    offer(2, 3'd6, 3'd2, 4'd1, 16'h1234);
    tick();
    srcValid = '0;
    chk("mrst_held", 32'(srcReady), 32'hB);
    #2 reset_n = 1'b0;
    expCount = 0;
    #1;
    chk("mrst_ready", 32'(srcReady), 32'hF);
    chk("mrst_cnt", 32'(bcastCount), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mrst_nocdb", 32'(cdbValid), 0);
    chk("mrst_cnt2", 32'(bcastCount), 0);

    // round-robin order from pointer 0
    for (int i = 0; i < 4; i++)
      offer(i, 3'(i + 4), 3'(i + 1), 4'd0, 16'(16'h100 + i));
    tick();
    srcValid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expCount++;
      chk("rr_v", 32'(cdbValid), 1);
      chk("rr_src", 32'(cdbSrc), 32'(i));
      chk("rr_tag", 32'(cdbTag), 32'(i + 4));
      chk("rr_data", 32'(cdbData), 32'h100 + 32'(i));
    end
    chk("rr_cnt", 32'(bcastCount), 32'(expCount));
    tick();
    chk("rr_idle", 32'(cdbValid), 0);

    // write-back mask and dest-zero suppression
    offer(0, 3'd1, 3'd4, 4'd2, 16'h0F0F);
    tick();
    srcValid = '0;
    tick();
    expCount++;
    chk("wb_op2_v", 32'(cdbValid), 1);
    chk("wb_op2_we", 32'(rfWe), 0);
    offer(1, 3'd2, 3'd0, 4'd4, 16'h5555);
    tick();
    srcValid = '0;
    tick();
    expCount++;
    chk("wb_d0_v", 32'(cdbValid), 1);
    chk("wb_d0_we", 32'(rfWe), 0);
    offer(2, 3'd7, 3'd7, 4'd5, 16'hBEEF);
    tick();
    srcValid = '0;
    tick();
    expCount++;
    chk("wb_div_we", 32'(rfWe), 1);
    chk("wb_div_addr", 32'(rfAddr), 7);
    chk("wb_div_rfd", 32'(rfData), 32'hBEEF);
    chk("wb_cnt", 32'(bcastCount), 32'(expCount));

    // flush with two full buffers and a concurrent offer
    offer(0, 3'd1, 3'd1, 4'd0, 16'h0001);
    offer(3, 3'd2, 3'd2, 4'd0, 16'h0002);
    tick();
    srcValid = '0;
    chk("fl_full", 32'(srcReady), 32'h6);
    flush = 1'b1;
    offer(2, 3'd3, 3'd3, 4'd0, 16'h0003);
    tick();
    flush = 1'b0;
    srcValid = '0;
    chk("fl_nocdb", 32'(cdbValid), 0);
    chk("fl_ready", 32'(srcReady), 32'hF);
    chk("fl_cnt", 32'(bcastCount), 32'(expCount));
    tick();
    chk("fl_nocap", 32'(cdbValid), 0);
    chk("fl_ready2", 32'(srcReady), 32'hF);

    // saturation: every channel offered whenever ready
    for (int i = 0; i < 4; i++) begin
      offer(i, 3'(i), 3'(i + 1), 4'd0, 16'(i));
      grants[i] = 0;
    end
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (cdbValid) grants[cdbSrc]++;
    end
    for (int i = 0; i < 4; i++)
      chk("sat_fair", 32'(grants[i] >= 249 && grants[i] <= 251), 1);
    chk("sat_cnt", 32'(bcastCount), 32'((expCount + 999) % 65536));
    for (int c = 0; c < 64600; c++) tick();
    chk("sat_wrap", 32'(bcastCount),
        32'((expCount + 65599) % 65536));
    srcValid = '0;

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
